// File: rtl/riscv_pkg.sv
// riscv_pkg: shared pipeline control bundle layout and ALU operation encodings
package riscv_pkg;
    localparam int CTRL_W = 10;
    localparam int CTRL_REG_WRITE = 9;
    localparam int CTRL_MEM_READ = 8;
    localparam int CTRL_MEM_WRITE = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_SRC = 5;
    localparam int CTRL_BRANCH = 4;
    localparam int CTRL_ALU_OP_LSB = 0;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
        logic [3:0] alu_op;
    } ctrl_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its maximum value instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: decode-to-execute pipeline register with stall, flush and bubble/stall counters
module id_ex_register import riscv_pkg::*; #(
    parameter int XLEN = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  ctrl_t            id_ctrl,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output ctrl_t            ex_ctrl,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_ctrl  <= '0;
        end else if (!stall) begin
            ex_valid <= id_valid;
            ex_pc    <= id_pc;
            ex_rd1   <= id_rd1;
            ex_rd2   <= id_rd2;
            ex_imm   <= id_imm;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            // an invalid slot must never carry side-effecting controls downstream
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end
    sat_counter #(.CNT_W(CNT_W)) u_bubble (
        .clk(clk), .reset(reset), .inc(flush || (!stall && !id_valid)), .count(bubble_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk(clk), .reset(reset), .inc(stall && !flush), .count(stall_cnt)
    );
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: random + directed stimulus against a rule-level model, scoreboard-checked
module tb_id_ex_register;
    typedef struct packed {
        logic        v;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [9:0]  ctrl;
        logic [3:0]  bc, sc;
    } st_t;
    logic clk = 1'b0;
    logic reset = 1'b0, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [9:0] id_ctrl = '0;
    logic ex_valid;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [9:0] ex_ctrl;
    logic [3:0] bubble_cnt, stall_cnt;
    st_t q[$];
    st_t model = '0;
    int total = 0, bad = 0;
    id_ex_register #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    function automatic logic [3:0] sat(input logic [3:0] x);
        int n = int'(x) + 1;
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction
    function automatic st_t act_now();
        return '{ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl, bubble_cnt, stall_cnt};
    endfunction
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask
    // apply one cycle of inputs, push the predicted post-edge state, return at the next negedge
    task automatic cyc(input logic r, input logic f, input logic s, input logic v,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [9:0] c);
        st_t n;
        reset = r; flush = f; stall = s; id_valid = v;
        id_pc = pc; id_rd1 = a; id_rd2 = b; id_imm = im;
        id_rs1 = s1; id_rs2 = s2; id_rd = d; id_ctrl = c;
        if (r) n = '0;
        else if (f) begin
            n = '0;
            n.bc = sat(model.bc);
            n.sc = model.sc;
        end else if (s) begin
            n = model;
            n.sc = sat(model.sc);
        end else begin
            n = '{v, pc, a, b, im, s1, s2, d, v ? c : 10'h0, v ? model.bc : sat(model.bc), model.sc};
        end
        model = n;
        q.push_back(n);
        @(negedge clk);
    endtask
    task automatic rcyc(input logic r, input logic f, input logic s, input logic v);
        cyc(r, f, s, v, $urandom, $urandom, $urandom, $urandom, 5'($urandom_range(31)),
            5'($urandom_range(31)), 5'($urandom_range(31)), 10'($urandom_range(1023)));
    endtask
    initial begin
        st_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                a = act_now();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL scoreboard @%0t: got=%h want=%h", $time, a, e);
                end
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end
    initial begin
        @(negedge clk);
        rcyc(1, 1, 1, 1);
        chk("reset_all_zero", 64'(act_now()), 64'(act_now() & 0) | 64'h0);
        chk("reset_pc", 64'(ex_pc), 64'h0);
        cyc(0, 0, 0, 1, 32'h40, 32'h11, 32'h22, 32'hFFFFF800, 5'd1, 5'd2, 5'd3, 10'h3A3);
        chk("load_pc", 64'(ex_pc), 64'h40);
        chk("load_imm", 64'(ex_imm), 64'hFFFFF800);
        chk("load_ctrl", 64'(ex_ctrl), 64'h3A3);
        chk("load_valid", 64'(ex_valid), 64'h1);
        repeat (3) rcyc(0, 0, 1, 1);
        chk("stall_pc_held", 64'(ex_pc), 64'h40);
        chk("stall_ctrl_held", 64'(ex_ctrl), 64'h3A3);
        chk("stall_cnt3", 64'(stall_cnt), 64'h3);
        rcyc(0, 1, 1, 1);
        chk("fs_valid", 64'(ex_valid), 64'h0);
        chk("fs_ctrl", 64'(ex_ctrl), 64'h0);
        chk("fs_bubble", 64'(bubble_cnt), 64'h1);
        chk("fs_stall_kept", 64'(stall_cnt), 64'h3);
        cyc(0, 0, 0, 0, 32'h80, 32'h5, 32'h6, 32'h7, 5'd4, 5'd5, 5'd6, 10'h3FF);
        chk("inv_ctrl", 64'(ex_ctrl), 64'h0);
        chk("inv_data", 64'(ex_pc), 64'h80);
        chk("inv_bubble", 64'(bubble_cnt), 64'h2);
        cyc(0, 0, 0, 1, 32'h100, 32'h1, 32'h2, 32'h3, 5'd7, 5'd8, 5'd9, 10'h2A5);
        repeat (2) rcyc(0, 0, 1, 1);
        rcyc(1, 0, 1, 1);
        chk("rst_mid_stall_pc", 64'(ex_pc), 64'h0);
        chk("rst_mid_stall_cnt", 64'(stall_cnt), 64'h0);
        cyc(0, 0, 0, 1, 32'h200, 32'h9, 32'hA, 32'hB, 5'd10, 5'd11, 5'd12, 10'h0C4);
        chk("post_rst_load", 64'(ex_pc), 64'h200);
        rcyc(1, 0, 0, 1);
        repeat (20) rcyc(0, 1, 0, 1);
        chk("bubble_sat", 64'(bubble_cnt), 64'hF);
        repeat (20) rcyc(0, 0, 1, 1);
        chk("stall_sat", 64'(stall_cnt), 64'hF);
        for (int i = 0; i < 600; i++)
            rcyc($urandom_range(99) < 3, $urandom_range(99) < 15, $urandom_range(99) < 25,
                 $urandom_range(99) < 80);
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
